// File: rtl/serializer_word_feeder.sv
// Word feeder for the tree serializer: FIFO-buffers source words and holds each on PAR_OUT for WIDTH cycles.
// Optional macro SER_FEED_PRBS_IDLE_EN replaces the constant idle filler with a PRBS7 sequence.
module serializer_word_feeder #(
    parameter int          WIDTH      = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IDLE_WORD  = 32'hAA,
    localparam int         LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             WORD_STB,
    output logic [LVL_W-1:0] FIFO_LEVEL,
    output logic             UNDERFLOW,
    input  logic             CLR_UNDERFLOW
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PH_W  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] IDLE = IDLE_WORD[WIDTH-1:0];

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PH_W-1:0]  phase;
    logic             primed;

    logic             push;
    logic             pop;
    logic             load;
    logic             empty;
    logic             uf_set;
    logic [WIDTH-1:0] idle_word;

    assign IN_READY = (FIFO_LEVEL != LVL_W'(FIFO_DEPTH));

    always_comb begin
        empty  = (FIFO_LEVEL == '0);
        push   = IN_VALID & IN_READY;
        load   = ENABLE & (phase == PH_W'(WIDTH - 1));
        pop    = load & ~empty;
        uf_set = load & empty & primed;
    end

`ifdef SER_FEED_PRBS_IDLE_EN
    logic [6:0] prbs;
    logic [6:0] prbs_next;
    logic [6:0] prbs_work;
    logic       prbs_bit;

    // Unroll WIDTH LFSR steps per idle load; first generated bit lands in bit 0.
    always_comb begin
        idle_word = '0;
        prbs_work = prbs;
        prbs_bit  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            prbs_bit     = prbs_work[6] ^ prbs_work[5];
            idle_word[i] = prbs_bit;
            prbs_work    = {prbs_work[5:0], prbs_bit};
        end
        prbs_next = prbs_work;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            prbs <= 7'h7F;
        else if (load && empty)
            prbs <= prbs_next;
    end
`else
    assign idle_word = IDLE;
`endif

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= IN_DATA;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            phase      <= '0;
            primed     <= 1'b0;
            PAR_OUT    <= IDLE;
            WORD_STB   <= 1'b0;
            UNDERFLOW  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
                2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
                default: FIFO_LEVEL <= FIFO_LEVEL;
            endcase

            if (ENABLE) begin
                phase    <= phase + 1'b1;
                WORD_STB <= load;
                if (load) begin
                    if (!empty) begin
                        PAR_OUT <= mem[rd_ptr];
                        primed  <= 1'b1;
                    end else begin
                        PAR_OUT <= idle_word;
                    end
                end
            end else begin
                phase    <= '0;
                PAR_OUT  <= IDLE;
                WORD_STB <= 1'b0;
                primed   <= 1'b0;
            end

            if (uf_set)
                UNDERFLOW <= 1'b1;
            else if (CLR_UNDERFLOW)
                UNDERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serializer_word_feeder.sv
// Directed plus randomized bench for serializer_word_feeder against a queue-based reference model.
module tb_serializer_word_feeder;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] par_out;
    logic         word_stb;
    logic [2:0]   fifo_level;
    logic         underflow;
    logic         clr_underflow;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_par;
    logic         m_stb;
    logic         m_uf;
    logic         m_primed;
    int           en_cnt;
    logic [6:0]   m_prbs;

    always #5 clk = ~clk;

    serializer_word_feeder #(.WIDTH(W), .FIFO_DEPTH(D), .IDLE_WORD(32'hAA)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .ENABLE(enable),
        .IN_DATA(in_data),
        .IN_VALID(in_valid),
        .IN_READY(in_ready),
        .PAR_OUT(par_out),
        .WORD_STB(word_stb),
        .FIFO_LEVEL(fifo_level),
        .UNDERFLOW(underflow),
        .CLR_UNDERFLOW(clr_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_idle();
        logic [W-1:0] w;
        w = 8'hAA;
`ifdef SER_FEED_PRBS_IDLE_EN
        for (int i = 0; i < W; i++) begin
            logic b;
            b      = m_prbs[6] ^ m_prbs[5];
            w[i]   = b;
            m_prbs = {m_prbs[5:0], b};
        end
`endif
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_par    = 8'hAA;
        m_stb    = 1'b0;
        m_uf     = 1'b0;
        m_primed = 1'b0;
        en_cnt   = 0;
        m_prbs   = 7'h7F;
    endtask

    // One clock: check IN_READY, advance the model, clock the DUT, compare registered outputs.
    task automatic step();
        logic push;
        logic load;
        logic set_uf;
        chk("in_ready", in_ready, q.size() != D);
        push   = in_valid && (q.size() != D);
        load   = enable && (en_cnt % W == W - 1);
        set_uf = 1'b0;
        if (!enable) begin
            m_par    = 8'hAA;
            m_stb    = 1'b0;
            m_primed = 1'b0;
            en_cnt   = 0;
        end else begin
            m_stb = load;
            if (load) begin
                if (q.size() > 0) begin
                    m_par    = q.pop_front();
                    m_primed = 1'b1;
                end else begin
                    m_par  = model_idle();
                    set_uf = m_primed;
                end
            end
            en_cnt++;
        end
        if (push)
            q.push_back(in_data);
        if (set_uf)
            m_uf = 1'b1;
        else if (clr_underflow)
            m_uf = 1'b0;
        @(posedge clk);
        #1;
        chk("par_out", par_out, m_par);
        chk("word_stb", word_stb, m_stb);
        chk("fifo_level", fifo_level, q.size());
        chk("underflow", underflow, m_uf);
    endtask

    task automatic run_to_load();
        while (en_cnt % W != W - 1)
            step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_par_out", par_out, 8'hAA);
        chk("rst_word_stb", word_stb, 1'b0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_underflow", underflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        enable        = 1'b0;
        in_data       = '0;
        in_valid      = 1'b0;
        clr_underflow = 1'b0;
        rst_n         = 1'b1;
        #3;
        do_reset();

`ifdef SER_FEED_PRBS_IDLE_EN
        enable = 1'b1;
        repeat (W) step();
        chk("prbs_first_idle", par_out, 8'h40);
        enable = 1'b0;
        step();
        do_reset();
`endif

        // idle stream only
        enable = 1'b1;
        repeat (3 * W) step();
        chk("t1_no_underflow", underflow, 1'b0);

        // three words then starve
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (5 * W) step();
        chk("t2_underflow", underflow, 1'b1);

        // clear alone, then clear coincident with an underflow load
        run_to_load();
        step();
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("t4_cleared", underflow, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        run_to_load();
        step();
        run_to_load();
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("t4_set_wins", underflow, 1'b1);
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("t4_clear_after", underflow, 1'b0);

        // fill while disabled
        enable = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            if (i == 4)
                chk("t3_ready_low", in_ready, 1'b0);
            step();
        end
        in_valid = 1'b0;
        chk("t3_level_full", fifo_level, 4);

        // reset mid-word with three words buffered
        enable = 1'b1;
        run_to_load();
        step();
        repeat (3) step();
        chk("t5_pre_level", fifo_level, 3);
        do_reset();

        // randomized traffic
        repeat (800) begin
            enable        = ($urandom_range(0, 99) < 96);
            in_valid      = ($urandom_range(0, 99) < 14);
            in_data       = W'($urandom);
            clr_underflow = ($urandom_range(0, 99) < 4);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
